pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter / fetch-address generator; next generation of the core's PC block.
- Sits at the front of the fetch stage and drives the instruction-memory address and chip-enable.
- Adds over the previous PC:
  - configurable width, reset vector and step;
  - stall (hold) input;
  - jump redirect with a one-entry pending buffer for redirects that arrive during a stall;
  - ready/valid handshake toward instruction memory;
  - alignment fault flag.

Parameters:
- ADDR_W, 32, width of pc_o and all address inputs.
- RESET_ADDR, 32'h0000_0000, first fetch address after reset; must be aligned.
- STEP, 4, byte increment per accepted fetch.
- ALIGN_BITS, 2, number of low address bits that are forced to zero on redirect.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-low reset.
- hold_i  in  1  pipeline stall; freezes pc_o.
- jump_i  in  1  redirect request, single-cycle qualifier.
- jump_addr_i  in  ADDR_W  redirect target.
- ready_i  in  1  instruction memory accepts the current pc_o.
- pc_o  out  ADDR_W  current fetch address.
- ce_o  out  1  instruction-memory chip enable.
- valid_o  out  1  pc_o is a fetch request.
- misalign_o  out  1  one-cycle pulse: a redirect target had nonzero low bits.
- redir_pend_o  out  1  a buffered redirect is waiting.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - pc_o=RESET_ADDR; ce_o=0; valid_o=0; misalign_o=0; redir_pend_o=0;
  - pending address register=0; state=IDLE.
- States:
  - IDLE: entered only by reset; ce_o=0, valid_o=0. On the first clk edge with rst_i=1, go to RUN, setting ce_o<=1 and valid_o<=1. pc_o stays RESET_ADDR, so the first request is RESET_ADDR on cycle 1 after reset release.
  - RUN: ce_o=1 and valid_o=1 continuously. Leaves RUN only on reset.
- Next-pc priority each RUN cycle, highest first:
  1. jump_i=1 and hold_i=0: pc_o <= aligned(jump_addr_i). Any pending redirect is discarded. Applies regardless of ready_i.
  2. jump_i=1 and hold_i=1: pending <= aligned(jump_addr_i); redir_pend_o<=1; pc_o unchanged. A newer jump overwrites an older pending one.
  3. hold_i=1: pc_o unchanged; pending preserved.
  4. redir_pend_o=1 and hold_i=0: pc_o <= pending; redir_pend_o<=0. Applies regardless of ready_i.
  5. ready_i=1: pc_o <= pc_o + STEP, modulo 2^ADDR_W. 0xFFFF_FFFC + 4 gives 0x0000_0000 with no flag.
  6. Otherwise pc_o is unchanged; the request is held stable until ready_i=1.
- aligned(x) = x with bits [ALIGN_BITS-1:0] cleared.
  - misalign_o <= 1 for exactly one cycle when a captured or applied target (cases 1 and 2) has any of those bits set; otherwise 0.
- Redirect latency: jump_i sampled at edge N → pc_o = target after edge N; no bubble.
- hold_i and ready_i both 1: hold wins; no advance.
- Reset mid-operation: everything returns to the reset values immediately and the pending redirect is lost. Restart follows IDLE→RUN.
- All registered outputs change only on the clk_i rising edge, except on reset.

Optional Feature:
- Macro: PC_GEN_TRAP_EN.
- Defined:
  - Adds ports trap_i (in, 1) and trap_vec_i (in, ADDR_W).
  - trap_i=1 in RUN has priority above all cases, including hold_i: pc_o <= aligned(trap_vec_i); pending cleared; redir_pend_o<=0.
  - Misalignment of trap_vec_i raises misalign_o as for jumps.
- Undefined: the ports are absent and behaviour is exactly as above.

Test Plan:
- Reset release, RESET_ADDR=0x100, ready_i=1 → valid_o rises cycle 1 with pc_o=0x100, then 0x104, 0x108 on successive cycles; ce_o=0 during reset.
- ready_i=0 for 3 cycles at pc 0x108 → pc_o stays 0x108; after ready_i=1, next edge gives 0x10C.
- jump_i=1, jump_addr_i=0x2003, hold_i=0 → next pc_o=0x2000 and misalign_o pulses 1 cycle; then 0x2004.
- hold_i=1 for 4 cycles, jump to 0x400 in cycle 2 and 0x500 in cycle 3 → redir_pend_o=1, pc_o frozen; first cycle after hold drops gives pc_o=0x500 and redir_pend_o=0.
- pc_o=0xFFFF_FFFC, ready_i=1 → pc_o=0x0000_0000. Assert rst_i=0 mid-cycle → outputs reset without waiting for a clock edge.
- With PC_GEN_TRAP_EN defined: trap_i with trap_vec_i=0x80, hold_i=1, jump_i=1 → pc_o=0x80 and pending cleared.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter / fetch-address generator for the front of the fetch stage.
// Drives the instruction-memory address, chip enable and a valid qualifier
// toward a ready/valid memory port. A redirect that arrives while the pipeline
// is stalled is parked in a one-entry pending buffer and applied on the first
// unstalled cycle.
//
// Optional feature: define PC_GEN_TRAP_EN to add trap_i / trap_vec_i, a
// redirect that overrides everything, including hold_i.
module pc_gen #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       ALIGN_BITS = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,        // asynchronous, active low
  input  logic              hold_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ready_i,
`ifdef PC_GEN_TRAP_EN
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
`endif
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              valid_o,
  output logic              misalign_o,
  output logic              redir_pend_o
);

  // Low address bits that must be zero in any fetch target.
  localparam logic [ADDR_W-1:0] LowMask = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [ADDR_W-1:0] StepInc = ADDR_W'(STEP);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic              misalign_q, misalign_d;
  logic              ce_q, ce_d;
  logic              valid_q, valid_d;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
    return addr & ~LowMask;
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return |(addr & LowMask);
  endfunction

  // Next-state: IDLE->RUN sequencing and the next-pc priority chain.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    misalign_d   = 1'b0;
    ce_d         = ce_q;
    valid_d      = valid_q;

    unique case (state_q)
      StIdle: begin
        // First request is RESET_ADDR itself, so pc does not advance here.
        state_d = StRun;
        ce_d    = 1'b1;
        valid_d = 1'b1;
      end
      StRun: begin
        ce_d    = 1'b1;
        valid_d = 1'b1;
`ifdef PC_GEN_TRAP_EN
        if (trap_i) begin
          pc_d         = align_addr(trap_vec_i);
          pend_valid_d = 1'b0;
          pend_addr_d  = '0;
          misalign_d   = is_misaligned(trap_vec_i);
        end else
`endif
        if (jump_i && !hold_i) begin
          // Applied immediately; an older parked redirect is stale now.
          pc_d         = align_addr(jump_addr_i);
          pend_valid_d = 1'b0;
          misalign_d   = is_misaligned(jump_addr_i);
        end else if (jump_i && hold_i) begin
          // Newest redirect wins the single pending slot.
          pend_addr_d  = align_addr(jump_addr_i);
          pend_valid_d = 1'b1;
          misalign_d   = is_misaligned(jump_addr_i);
        end else if (hold_i) begin
          pc_d = pc_q;
        end else if (pend_valid_q) begin
          pc_d         = pend_addr_q;
          pend_valid_d = 1'b0;
        end else if (ready_i) begin
          pc_d = pc_q + StepInc;
        end
      end
      default: begin
        state_d = StIdle;
        ce_d    = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset restores the power-on fetch state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      pc_q         <= RESET_ADDR;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      ce_q         <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      misalign_q   <= misalign_d;
      ce_q         <= ce_d;
      valid_q      <= valid_d;
    end
  end

  assign pc_o         = pc_q;
  assign ce_o         = ce_q;
  assign valid_o      = valid_q;
  assign misalign_o   = misalign_q;
  assign redir_pend_o = pend_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a directed vector table for the main
// scenarios, hand-written reset sequences, and randomized traffic compared
// against a behavioural model of the next-pc rules.
module tb_pc_gen;

  localparam logic [31:0] ResetAddr = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, jump, ready;
  logic [31:0] jaddr;
  logic [31:0] pc;
  logic        ce, valid, misalign, pend;
`ifdef PC_GEN_TRAP_EN
  logic        trap;
  logic [31:0] trap_vec;
`endif

  pc_gen #(
    .ADDR_W    (32),
    .RESET_ADDR(ResetAddr),
    .STEP      (4),
    .ALIGN_BITS(2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .hold_i      (hold),
    .jump_i      (jump),
    .jump_addr_i (jaddr),
    .ready_i     (ready),
`ifdef PC_GEN_TRAP_EN
    .trap_i      (trap),
    .trap_vec_i  (trap_vec),
`endif
    .pc_o        (pc),
    .ce_o        (ce),
    .valid_o     (valid),
    .misalign_o  (misalign),
    .redir_pend_o(pend)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model state.
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  bit          m_mis;

  typedef struct {
    logic        hold;
    logic        jump;
    logic [31:0] jaddr;
    logic        ready;
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_run = 0; m_pc = ResetAddr; m_pend = 0; m_pend_addr = '0; m_mis = 0;
  endfunction

  // One rising edge worth of the spec's next-pc rules, highest priority first.
  function automatic void model_edge(input bit h, input bit j, input logic [31:0] ja,
                                     input bit r, input bit t, input logic [31:0] tv);
    m_mis = 0;
    if (!m_run) begin
      m_run = 1;
    end else if (t) begin
      m_pc = {tv[31:2], 2'b00}; m_pend = 0; m_mis = (tv % 4) != 0;
    end else if (j && !h) begin
      m_pc = {ja[31:2], 2'b00}; m_pend = 0; m_mis = (ja % 4) != 0;
    end else if (j && h) begin
      m_pend_addr = {ja[31:2], 2'b00}; m_pend = 1; m_mis = (ja % 4) != 0;
    end else if (h) begin
      // frozen
    end else if (m_pend) begin
      m_pc = m_pend_addr; m_pend = 0;
    end else if (r) begin
      m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".valid"}, {31'b0, valid}, {31'b0, m_run});
    check({tag, ".ce"}, {31'b0, ce}, {31'b0, m_run});
    check({tag, ".misalign"}, {31'b0, misalign}, {31'b0, m_mis});
    check({tag, ".pend"}, {31'b0, pend}, {31'b0, m_pend});
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, return at
  // the next falling edge with the model advanced.
  task automatic cycle(input bit h, input bit j, input logic [31:0] ja, input bit r,
                       input bit t, input logic [31:0] tv);
    hold = h; jump = j; jaddr = ja; ready = r;
`ifdef PC_GEN_TRAP_EN
    trap = t; trap_vec = tv;
`endif
    @(posedge clk);
`ifdef PC_GEN_TRAP_EN
    model_edge(h, j, ja, r, t, tv);
`else
    model_edge(h, j, ja, r, 1'b0, tv);
`endif
    @(negedge clk);
  endtask

  function automatic void add(input bit h, input bit j, input logic [31:0] ja, input bit r,
                              input logic [31:0] p, input bit mi, input bit pe);
    vec_t v;
    v.hold = h; v.jump = j; v.jaddr = ja; v.ready = r;
    v.exp_pc = p; v.exp_mis = mi; v.exp_pend = pe;
    vecs.push_back(v);
  endfunction

  initial begin
    // Directed vectors, applied from reset release.
    add(0, 0, 0, 1, 32'h100, 0, 0);          // IDLE->RUN, first request 0x100
    add(0, 0, 0, 1, 32'h104, 0, 0);
    add(0, 0, 0, 1, 32'h108, 0, 0);
    add(0, 0, 0, 0, 32'h108, 0, 0);          // memory not ready x3
    add(0, 0, 0, 0, 32'h108, 0, 0);
    add(0, 0, 0, 0, 32'h108, 0, 0);
    add(0, 0, 0, 1, 32'h10C, 0, 0);
    add(0, 1, 32'h2003, 1, 32'h2000, 1, 0);  // misaligned jump
    add(0, 0, 0, 1, 32'h2004, 0, 0);
    add(1, 0, 0, 1, 32'h2004, 0, 0);          // hold x4 with two jumps
    add(1, 1, 32'h400, 1, 32'h2004, 0, 1);
    add(1, 1, 32'h500, 1, 32'h2004, 0, 1);
    add(1, 0, 0, 1, 32'h2004, 0, 1);
    add(0, 0, 0, 1, 32'h500, 0, 0);           // newest pending applied
    add(0, 0, 0, 1, 32'h504, 0, 0);
    add(1, 1, 32'h3001, 0, 32'h504, 1, 1);    // capture misaligned while held
    add(0, 0, 0, 0, 32'h3000, 0, 0);          // pending applies without ready
    add(1, 0, 0, 1, 32'h3000, 0, 0);          // hold beats ready
    add(0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0);
    add(0, 0, 0, 1, 32'h0000_0000, 0, 0);     // wrap, no flag
    add(1, 1, 32'h600, 1, 32'h0, 0, 1);
    add(0, 1, 32'h700, 1, 32'h700, 0, 0);     // unheld jump discards pending
    add(0, 0, 0, 1, 32'h704, 0, 0);

    hold = 0; jump = 0; jaddr = '0; ready = 0;
`ifdef PC_GEN_TRAP_EN
    trap = 0; trap_vec = '0;
`endif
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.pc", pc, ResetAddr);
    check("reset.ce", {31'b0, ce}, 32'd0);
    check("reset.valid", {31'b0, valid}, 32'd0);
    check("reset.pend", {31'b0, pend}, 32'd0);
    check("reset.misalign", {31'b0, misalign}, 32'd0);
    rst_n = 1;

    foreach (vecs[i]) begin
      cycle(vecs[i].hold, vecs[i].jump, vecs[i].jaddr, vecs[i].ready, 1'b0, '0);
      check($sformatf("vec%0d.pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d.misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      check($sformatf("vec%0d.pend", i), {31'b0, pend}, {31'b0, vecs[i].exp_pend});
      check($sformatf("vec%0d.valid", i), {30'b0, ce, valid}, 32'd3);
      check_model($sformatf("vec%0d.model", i));
    end

    // Park a redirect, then reset between edges: everything clears at once.
    cycle(1, 1, 32'h900, 1, 1'b0, '0);
    check("prerst.pend", {31'b0, pend}, 32'd1);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("asyncrst.pc", pc, ResetAddr);
    check("asyncrst.ce", {31'b0, ce}, 32'd0);
    check("asyncrst.valid", {31'b0, valid}, 32'd0);
    check("asyncrst.pend", {31'b0, pend}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    cycle(0, 0, 0, 1, 1'b0, '0);
    check("restart.pc", pc, ResetAddr);
    check("restart.valid", {31'b0, valid}, 32'd1);
    cycle(0, 0, 0, 1, 1'b0, '0);
    check("restart.pc2", pc, ResetAddr + 32'd4);
    check_model("restart");

`ifdef PC_GEN_TRAP_EN
    // Trap overrides hold and a simultaneous jump, and drops the pending slot.
    cycle(1, 1, 32'hA00, 1, 1'b0, '0);
    cycle(1, 1, 32'hB00, 1, 1'b1, 32'h80);
    check("trap.pc", pc, 32'h80);
    check("trap.pend", {31'b0, pend}, 32'd0);
    cycle(1, 0, 0, 1, 1'b1, 32'hC2);
    check("trap.misalign", {31'b0, misalign}, 32'd1);
    check_model("trap");
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit          h, j, r, t;
      logic [31:0] ja, tv;
      h  = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 4) == 0);
      r  = ($urandom_range(0, 3) != 0);
      t  = 1'b0;
`ifdef PC_GEN_TRAP_EN
      t  = ($urandom_range(0, 15) == 0);
`endif
      ja = $urandom();
      tv = $urandom();
      if ($urandom_range(0, 7) == 0) ja = 32'hFFFF_FFF0 | (ja & 32'hF);
      cycle(h, j, ja, r, t, tv);
      check_model($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
